// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit layout and transmitter FSM states.
package uart_tx_periph_pkg;

    localparam logic [31:0] REG_DATA   = 32'd0;
    localparam logic [31:0] REG_STATUS = 32'd1;
    localparam logic [31:0] REG_CTRL   = 32'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf);
        logic [7:0] v;
        v             = 8'h00;
        v[STAT_BUSY]  = busy;
        v[STAT_FULL]  = full;
        v[STAT_EMPTY] = empty;
        v[STAT_OVF]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; pushes when full
// and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Write-only UART transmitter on the SoC byte bus: DATA/STATUS/CTRL registers,
// byte FIFO and an 8N1 serialiser with back-to-back frames.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        output_enable,
    input  logic [31:0] address,
    input  logic [7:0]  write_data,
    input  logic        write_enable,
    output logic [7:0]  read_data,
    output logic        illegal_address,
    output logic        tx,
    output logic        irq_empty
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [2:0]       r_bit_idx, w_bit_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_tx, w_tx_next;
    logic             r_overflow;
    logic             w_push_req, w_ctrl_clr, w_pop, w_bit_end;
    logic             w_fifo_full, w_fifo_empty;
    logic [7:0]       w_fifo_dout, w_read_mux;

    assign w_push_req = output_enable && write_enable && (address == REG_DATA);
    assign w_ctrl_clr = output_enable && write_enable && (address == REG_CTRL) && write_data[0];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (write_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            r_overflow <= 1'b0;
        else if (w_push_req && w_fifo_full) r_overflow <= 1'b1;
        else if (w_ctrl_clr)                r_overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign w_bit_end = (r_bit_cnt == CNT_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) w_state_next   = ST_STOP;
                    else                   w_bit_idx_next = r_bit_idx + 1'b1;
                end
            end
            ST_STOP: begin
                w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + 1'b1;
                if (w_bit_end) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // tx is computed from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        w_read_mux = 8'h00;
        if (address == REG_STATUS) begin
            w_read_mux = pack_status(r_state != ST_IDLE, w_fifo_full, w_fifo_empty, r_overflow);
        end
    end

    assign read_data       = output_enable ? w_read_mux : 8'bz;
    assign illegal_address = output_enable && (address > REG_CTRL);
    assign tx              = r_tx;
    assign irq_empty       = w_fifo_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLKS_PER_BIT=4 and a 4-entry FIFO.
module tb_uart_tx_periph;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        output_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address = 32'd0;
    logic [7:0]  write_data = 8'h00;
    wire  [7:0]  read_data;
    wire         illegal_address;
    wire         tx;
    wire         irq_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .output_enable   (output_enable),
        .address         (address),
        .write_data      (write_data),
        .write_enable    (write_enable),
        .read_data       (read_data),
        .illegal_address (illegal_address),
        .tx              (tx),
        .irq_empty       (irq_empty)
    );

    // Expected line level j cycles into a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j < CPB)          return 1'b0;
        else if (j < 9 * CPB) return b[j / CPB - 1];
        else                  return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        output_enable = 1'b1;
        address = 32'd1;
        #1;
        total++;
        if (read_data !== 8'h04) begin bad++; $display("FAIL reset_status: got %h want 04", read_data); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++;
        if (irq_empty !== 1'b1) begin bad++; $display("FAIL reset_irq: got %b want 1", irq_empty); end
    endtask

    task automatic test_single_frame();
        output_enable = 1'b1;
        write_enable = 1'b1;
        address = 32'd0;
        write_data = 8'h55;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        address = 32'd1;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (tx !== exp_bit(8'h55, k)) begin
                bad++; $display("FAIL single_tx k=%0d: got %b want %b", k, tx, exp_bit(8'h55, k));
            end
            total++;
            if (read_data[0] !== 1'b1) begin bad++; $display("FAIL single_busy k=%0d: got %b want 1", k, read_data[0]); end
            if (k == 0) begin
                total++;
                if (irq_empty !== 1'b0) begin bad++; $display("FAIL single_irq_busy: got %b want 0", irq_empty); end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (read_data !== 8'h04) begin bad++; $display("FAIL single_done_status: got %h want 04", read_data); end
        total++;
        if (irq_empty !== 1'b1) begin bad++; $display("FAIL single_done_irq: got %b want 1", irq_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic       e;
        int         k;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hF0;
        bytes[3] = 8'h0F; bytes[4] = 8'h81; bytes[5] = 8'hFF;
        for (int cyc = 0; cyc < 10 * CPB * 5 + 6; cyc++) begin
            output_enable = 1'b1;
            if (cyc < 6) begin
                write_enable = 1'b1;
                address = 32'd0;
                write_data = bytes[cyc];
            end else begin
                write_enable = 1'b0;
                address = 32'd1;
            end
            @(posedge clk);
            #1;
            if (cyc == 5) begin
                write_enable = 1'b0;
                address = 32'd1;
                #1;
                total++;
                if (read_data !== 8'h0B) begin bad++; $display("FAIL b2b_overflow_status: got %h want 0b", read_data); end
            end
            if (cyc >= 1) begin
                k = cyc - 1;
                e = (k < 10 * CPB * 5) ? exp_bit(bytes[k / (10 * CPB)], k % (10 * CPB)) : 1'b1;
                total++;
                if (tx !== e) begin bad++; $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx, e); end
            end
        end
        total++;
        if (read_data !== 8'h0C) begin bad++; $display("FAIL b2b_end_status: got %h want 0c", read_data); end
        write_enable = 1'b1;
        address = 32'd2;
        write_data = 8'h01;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        address = 32'd1;
        #1;
        total++;
        if (read_data !== 8'h04) begin bad++; $display("FAIL ctrl_clear_status: got %h want 04", read_data); end
    endtask

    task automatic test_decode();
        output_enable = 1'b1;
        write_enable = 1'b0;
        address = 32'd3;
        #1;
        total++;
        if (illegal_address !== 1'b1) begin bad++; $display("FAIL illegal_3: got %b want 1", illegal_address); end
        total++;
        if (read_data !== 8'h00) begin bad++; $display("FAIL read_3: got %h want 00", read_data); end
        address = 32'd2;
        #1;
        total++;
        if (illegal_address !== 1'b0) begin bad++; $display("FAIL illegal_2: got %b want 0", illegal_address); end
        output_enable = 1'b0;
        address = 32'd3;
        #1;
        total++;
        if (illegal_address !== 1'b0) begin bad++; $display("FAIL illegal_oe0: got %b want 0", illegal_address); end
        write_enable = 1'b1;
        address = 32'd0;
        write_data = 8'h00;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx !== 1'b1) begin bad++; $display("FAIL oe0_write_tx i=%0d: got %b want 1", i, tx); end
            @(posedge clk);
            #1;
        end
        output_enable = 1'b1;
        address = 32'd1;
        #1;
        total++;
        if (read_data !== 8'h04) begin bad++; $display("FAIL oe0_write_status: got %h want 04", read_data); end
    endtask

    task automatic test_reset_mid_frame();
        output_enable = 1'b1;
        write_enable = 1'b1;
        address = 32'd0;
        write_data = 8'h00;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        write_enable = 1'b0;
        address = 32'd1;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx: got %b want 0", tx); end
        total++;
        if (read_data !== 8'h01) begin bad++; $display("FAIL mid_pre_status: got %h want 01", read_data); end
        rst = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL mid_async_tx: got %b want 1", tx); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (read_data !== 8'h04) begin bad++; $display("FAIL mid_post_status: got %h want 04", read_data); end
        for (int i = 0; i < 12 * CPB; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (tx !== 1'b1) begin bad++; $display("FAIL mid_post_tx i=%0d: got %b want 1", i, tx); end
        end
        total++;
        if (irq_empty !== 1'b1) begin bad++; $display("FAIL mid_post_irq: got %b want 1", irq_empty); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_decode();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
